// File: rtl/mmac_matrix_loader.sv
// mmac_matrix_loader: serial-to-parallel feeder for the matrix MAC stage.
// Collects N elements of matrix A followed by N elements of matrix B from a
// valid/ready stream, packs each into a flattened row-major vector with
// element [0][0] in the MSBs, and offers the pair downstream on a second
// valid/ready handshake. Single-buffered: the stream stalls while a pair is
// waiting. Framing is checked against in_last, and delivered pairs are counted.
//
// Build option: define MMAC_LOADER_TRANSPOSE_B_EN to read the B stream in
// column-major order. The packed matrix_b layout stays row-major.

module mmac_matrix_loader #(
    parameter int VAR_WIDTH = 8,
    parameter int M_SIZE    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [VAR_WIDTH-1:0]                  in_data,
    input  logic                                  in_last,
    output logic                                  mat_valid,
    input  logic                                  mat_ready,
    output logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]    matrix_a,
    output logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]    matrix_b,
    output logic                                  frame_err,
    output logic [CNT_WIDTH-1:0]                  pair_cnt
);

    // state  | meaning
    // LOAD_A | accepting stream elements into matrix A
    // LOAD_B | accepting stream elements into matrix B
    // FULL   | complete pair presented downstream, stream stalled

    localparam int N     = M_SIZE * M_SIZE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [N*VAR_WIDTH-1:0]    matrix_a_q;
    logic [N*VAR_WIDTH-1:0]    matrix_b_q;
    logic                      mat_valid_q;
    logic                      in_ready_q;
    logic                      frame_err_q;
    logic [CNT_WIDTH-1:0]      pair_cnt_q;

    logic [IDX_W-1:0]          b_slot_d;
    logic                      beat_d;
    logic                      idx_last_d;

    // Map the B stream position to its row-major storage slot.
    always_comb begin
        b_slot_d = idx_q;
`ifdef MMAC_LOADER_TRANSPOSE_B_EN
        // Stream position idx = c*M + r lands in slot r*M + c.
        b_slot_d = IDX_W'((int'(idx_q) % M_SIZE) * M_SIZE + (int'(idx_q) / M_SIZE));
`endif
    end

    // Accept qualifier and end-of-matrix detect, both from registered state.
    always_comb begin
        beat_d     = in_valid && in_ready_q;
        idx_last_d = (idx_q == IDX_W'(N - 1));
    end

    // Loader FSM with registered handshake, error and counter outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            matrix_a_q  <= '0;
            matrix_b_q  <= '0;
            mat_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_err_q <= 1'b0;
            pair_cnt_q  <= '0;
        end else if (flush) begin
            // Abort wins over any beat or downstream handshake this cycle.
            state_q     <= LOAD_A;
            idx_q       <= '0;
            mat_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                LOAD_A: begin
                    if (beat_d) begin
                        matrix_a_q[(N-1-int'(idx_q))*VAR_WIDTH +: VAR_WIDTH] <= in_data;
                        if (in_last) begin
                            frame_err_q <= 1'b1;
                            idx_q       <= '0;
                        end else if (idx_last_d) begin
                            state_q <= LOAD_B;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (beat_d) begin
                        matrix_b_q[(N-1-int'(b_slot_d))*VAR_WIDTH +: VAR_WIDTH] <= in_data;
                        if (idx_last_d && in_last) begin
                            state_q     <= FULL;
                            idx_q       <= '0;
                            mat_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else if (idx_last_d || in_last) begin
                            // Misplaced or missing in_last: drop the frame,
                            // leave the partially written registers as they are.
                            state_q     <= LOAD_A;
                            idx_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (mat_ready) begin
                        state_q     <= LOAD_A;
                        idx_q       <= '0;
                        mat_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        pair_cnt_q  <= pair_cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q     <= LOAD_A;
                    idx_q       <= '0;
                    mat_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mat_valid = mat_valid_q;
    assign matrix_a  = matrix_a_q;
    assign matrix_b  = matrix_b_q;
    assign frame_err = frame_err_q;
    assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_mmac_matrix_loader.sv
// Testbench for mmac_matrix_loader: table of frame records plus hand-written
// sequences for reset, flush and the packing/transpose layout. Delivered
// pairs are compared against a queue of expected packed matrices.

module tb_mmac_matrix_loader;

    localparam int W  = 8;
    localparam int M  = 4;
    localparam int N  = M * M;
    localparam int CW = 16;
    localparam int MW = N * W;

    logic           clock = 1'b0;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           mat_valid;
    logic           mat_ready;
    logic [MW-1:0]  matrix_a;
    logic [MW-1:0]  matrix_b;
    logic           frame_err;
    logic [CW-1:0]  pair_cnt;

    always #5 clock = ~clock;

    mmac_matrix_loader #(.VAR_WIDTH(W), .M_SIZE(M), .CNT_WIDTH(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .frame_err (frame_err),
        .pair_cnt  (pair_cnt)
    );

    typedef struct packed {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
    } pair_t;

    typedef struct {
        bit          do_reset;
        int          err_beat;     // beat index carrying a stray in_last, -1 for none
        bit          no_last;      // final beat sent without in_last
        logic [7:0]  a_base;
        logic [7:0]  b_base;
        int          hold;         // cycles mat_ready is held low once FULL
        int          exp_err;
        bit          exp_deliver;
    } vec_t;

    pair_t sb_q[$];
    pair_t sb_e;
    int    n_checks  = 0;
    int    n_pass    = 0;
    int    err_total = 0;
    int    exp_cnt   = 0;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic logic [MW-1:0] pack_a(input logic [7:0] base);
        logic [MW-1:0] v = '0;
        for (int n = 0; n < N; n++) v[(N-1-n)*W +: W] = base + 8'(n);
        return v;
    endfunction

    function automatic logic [MW-1:0] pack_b(input logic [7:0] base);
        logic [MW-1:0] v = '0;
        int slot;
        for (int n = 0; n < N; n++) begin
`ifdef MMAC_LOADER_TRANSPOSE_B_EN
            slot = (n % M) * M + (n / M);
`else
            slot = n;
`endif
            v[(N-1-slot)*W +: W] = base + 8'(n);
        end
        return v;
    endfunction

    // Frame-error pulses and downstream handshakes, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset && frame_err) err_total++;
        if (reset && !flush && mat_valid && mat_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pair: actual=delivered expected=none");
            end else begin
                sb_e = sb_q.pop_front();
                check("pair_a", matrix_a, sb_e.a);
                check("pair_b", matrix_b, sb_e.b);
            end
        end
    end

    // All drives happen 1 time unit after a rising edge.
    task automatic do_reset();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_cnt  = 0;
        sb_q.delete();
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int   guard = 0;
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 100) begin
                n_checks++;
                $display("FAIL beat_timeout: actual=in_ready_low expected=accept");
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int            err0;
        int            nbeats;
        logic [7:0]    d;
        logic [MW-1:0] snap_a;
        if (v.do_reset) do_reset();
        err0      = err_total;
        mat_ready = (v.hold == 0);
        nbeats    = (v.err_beat >= 0) ? v.err_beat + 1 : 2 * N;
        if (v.exp_deliver) begin
            sb_q.push_back('{a: pack_a(v.a_base), b: pack_b(v.b_base)});
            exp_cnt++;
        end
        for (int b = 0; b < nbeats; b++) begin
            d = (b < N) ? v.a_base + 8'(b) : v.b_base + 8'(b - N);
            send_beat(d, (b == 2*N-1) ? !v.no_last : (b == v.err_beat));
        end
        if (v.exp_deliver && v.hold == 0) begin
            @(negedge clock);
            check("full_valid", MW'(mat_valid), MW'(1));
            check("full_ready", MW'(in_ready), MW'(0));
            @(posedge clock); #1;
            @(negedge clock);
            check("after_valid", MW'(mat_valid), MW'(0));
            check("after_ready", MW'(in_ready), MW'(1));
            @(posedge clock); #1;
        end else if (v.exp_deliver) begin
            snap_a = pack_a(v.a_base);
            for (int i = 0; i < v.hold; i++) begin
                in_valid = 1'b1;
                in_data  = 8'hEE;
                in_last  = 1'b1;
                @(negedge clock);
                check("hold_valid", MW'(mat_valid), MW'(1));
                check("hold_ready", MW'(in_ready), MW'(0));
                check("hold_a", matrix_a, snap_a);
                @(posedge clock); #1;
            end
            in_valid  = 1'b0;
            in_last   = 1'b0;
            mat_ready = 1'b1;
            @(negedge clock);
            @(posedge clock); #1;
        end
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("err_pulses", MW'(err_total - err0), MW'(v.exp_err));
        check("pair_cnt", MW'(pair_cnt), MW'(exp_cnt));
        check("sb_empty", MW'(sb_q.size()), MW'(0));
        check("idle_valid", MW'(mat_valid), MW'(0));
        @(posedge clock); #1;
    endtask

    vec_t vecs[7];

    initial begin
        int err0;
        vecs[0] = '{1, -1, 0, 8'd1,   8'd17,  0, 0, 1};
        vecs[1] = '{1, -1, 0, 8'd1,   8'd17, 10, 0, 1};
        vecs[2] = '{1,  4, 0, 8'd1,   8'd17,  0, 1, 0};
        vecs[3] = '{0, -1, 0, 8'h40,  8'h80,  0, 0, 1};
        vecs[4] = '{1, -1, 1, 8'd1,   8'd17,  0, 1, 0};
        vecs[5] = '{1, 20, 0, 8'h30,  8'h60,  0, 1, 0};
        vecs[6] = '{0, -1, 0, 8'hF0,  8'h08,  3, 0, 1};

        mat_ready = 1'b1;
        do_reset();
        @(negedge clock);
        check("rst_valid", MW'(mat_valid), MW'(0));
        check("rst_ready", MW'(in_ready), MW'(1));
        check("rst_err", MW'(frame_err), MW'(0));
        check("rst_cnt", MW'(pair_cnt), MW'(0));
        check("rst_a", matrix_a, '0);
        check("rst_b", matrix_b, '0);
        @(posedge clock); #1;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Packing layout, including the [0][1] / [1][0] slots of B.
        do_reset();
        mat_ready = 1'b0;
        sb_q.push_back('{a: pack_a(8'd1), b: pack_b(8'd17)});
        exp_cnt++;
        for (int b = 0; b < 2*N; b++) send_beat(8'(b + 1), b == 2*N-1);
        @(negedge clock);
        check("a00", MW'(matrix_a[127:120]), MW'(1));
        check("a33", MW'(matrix_a[7:0]), MW'(16));
        check("b00", MW'(matrix_b[127:120]), MW'(17));
        check("b33", MW'(matrix_b[7:0]), MW'(32));
`ifdef MMAC_LOADER_TRANSPOSE_B_EN
        check("b01", MW'(matrix_b[119:112]), MW'(21));
        check("b10", MW'(matrix_b[95:88]), MW'(18));
`else
        check("b01", MW'(matrix_b[119:112]), MW'(18));
        check("b10", MW'(matrix_b[95:88]), MW'(21));
`endif
        @(posedge clock); #1;
        mat_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("layout_cnt", MW'(pair_cnt), MW'(1));
        @(posedge clock); #1;

        // Flush while FULL with mat_ready: pair dropped, no count, no error.
        do_reset();
        mat_ready = 1'b0;
        err0 = err_total;
        for (int b = 0; b < 2*N; b++) send_beat(8'(b + 100), b == 2*N-1);
        flush     = 1'b1;
        mat_ready = 1'b1;
        @(negedge clock);
        check("pre_flush_valid", MW'(mat_valid), MW'(1));
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        check("flush_valid", MW'(mat_valid), MW'(0));
        check("flush_cnt", MW'(pair_cnt), MW'(0));
        check("flush_ready", MW'(in_ready), MW'(1));
        @(posedge clock); #1;
        @(negedge clock);
        check("flush_err", MW'(err_total - err0), MW'(0));
        @(posedge clock); #1;

        // Flush on A beat 9 discards that beat; the next 32 beats are a frame.
        err0 = err_total;
        for (int b = 0; b < 8; b++) send_beat(8'(b + 200), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b0;
        flush    = 1'b1;
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("flushA_err", MW'(err_total - err0), MW'(0));
        @(posedge clock); #1;
        run_frame('{0, -1, 0, 8'h50, 8'h90, 0, 0, 1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmac_matrix_loader.md
Name: mmac_matrix_loader

Overview:
- Upstream feeder for the matrix MAC unit.
- Accepts a serial stream of VAR_WIDTH elements over a valid/ready handshake: 16 elements of matrix A, then 16 elements of matrix B.
- Packs them into two flattened 4x4 matrix vectors and presents the pair to the MAC stage with a valid/ready handshake.
- Single-buffered; also checks frame framing and counts delivered pairs.

Parameters:
- VAR_WIDTH, 8, bit width of one matrix element.
- M_SIZE, 4, matrix dimension; elements per matrix N = M_SIZE*M_SIZE.
- CNT_WIDTH, 16, width of delivered-pair counter.

Ports:
- clock  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous abort of the current frame.
- in_valid  in  1  stream element valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  VAR_WIDTH  stream element.
- in_last  in  1  marks the final element (B, index N-1) of a frame.
- mat_valid  out  1  matrix_a/matrix_b hold a complete pair.
- mat_ready  in  1  MAC stage consumes the pair.
- matrix_a  out  N*VAR_WIDTH  packed matrix A.
- matrix_b  out  N*VAR_WIDTH  packed matrix B.
- frame_err  out  1  one-cycle pulse on framing error.
- pair_cnt  out  CNT_WIDTH  count of delivered pairs.

Behaviour:
- Reset (reset==0 at clock edge):
  - state=LOAD_A, idx=0.
  - matrix_a=0, matrix_b=0.
  - mat_valid=0, frame_err=0, pair_cnt=0.
  - Reset dominates flush and all handshakes.
- Packing:
  - Stream order is row-major; element n = r*M_SIZE + c.
  - Element n occupies bits [(N-1-n)*VAR_WIDTH +: VAR_WIDTH], so [0][0] sits in the MSBs.
  - Each element is written into its slot on the accepting edge; no arithmetic on data.
- States: LOAD_A, LOAD_B, FULL.
- in_ready = (state==LOAD_A || state==LOAD_B). Registered-state decode; no dependence on in_valid.
- A beat is accepted when in_valid && in_ready.
- LOAD_A:
  - Each beat writes A[idx] and increments idx.
  - The beat at idx==N-1 goes to LOAD_B with idx=0.
- LOAD_B:
  - Each beat writes B[idx] and increments idx.
  - The beat at idx==N-1 with in_last=1 goes to FULL; mat_valid=1 from the next cycle.
- Framing errors, each causing a frame_err pulse for exactly one cycle, then state=LOAD_A, idx=0:
  - in_last=1 on any accepted beat other than B index N-1.
  - in_last=0 on B index N-1.
  - Partially written matrix registers are not cleared; mat_valid stays 0.
- FULL:
  - mat_valid=1; matrix_a/matrix_b held stable; in_ready=0.
  - On mat_valid && mat_ready: pair_cnt increments (wraps modulo 2^CNT_WIDTH), state=LOAD_A, idx=0.
  - mat_valid=0 and in_ready=1 from the next cycle.
- Latency:
  - Last B beat accepted at edge t -> mat_valid high in the cycle after t.
  - Minimum period is 2N+1 cycles per pair with mat_ready tied high.
- flush:
  - When flush=1 (reset inactive), state=LOAD_A, idx=0, mat_valid=0 at the next edge.
  - Any beat presented in that cycle is discarded.
  - A pending FULL pair is dropped without incrementing pair_cnt.
  - No frame_err pulse.
  - flush has priority over a simultaneous mat_ready handshake or in_valid beat.
- mat_ready while not FULL is ignored.
- in_valid while in_ready=0 is ignored; upstream must hold data until accepted.

Optional Feature:
- Macro: MMAC_LOADER_TRANSPOSE_B_EN.
- When defined:
  - B stream is interpreted column-major: stream element n = c*M_SIZE + r is written to B slot r*M_SIZE + c.
  - Packed matrix_b layout is unchanged.
  - A is unaffected.
- When undefined: B is row-major, identical to A.
- Framing, handshake and latency are identical in both builds.

Test Plan:
- Reset then stream A=1..16 and B=17..32, in_last on beat 32, mat_ready=1 -> in_ready low for one cycle, mat_valid high one cycle.
  - matrix_a[127:120]=1, matrix_a[7:0]=16; matrix_b[127:120]=17, matrix_b[7:0]=32.
  - pair_cnt=1; in_ready high again the next cycle.
- Same stream with mat_ready=0 for 10 cycles -> mat_valid held 10 cycles, outputs stable, in_ready=0, in_valid beats ignored.
  - mat_ready=1 then -> pair_cnt=1.
- in_last=1 on A beat 5 -> frame_err pulses one cycle, idx resets.
  - A following clean 32-beat frame delivers correct data and pair_cnt=1.
- Clean frame with in_last=0 on beat 32 -> frame_err pulse, mat_valid never asserts, pair_cnt=0.
- flush asserted in FULL together with mat_ready=1 -> mat_valid=0 next cycle, pair_cnt unchanged, no frame_err.
  - flush at A beat 9 -> next 32 beats form a new frame.
- TRANSPOSE_B build, B stream 17..32 -> matrix_b slot [0][1] (bits [119:112]) = 21, slot [1][0] = 18.
